// File: rtl/rr_burst_arbiter.sv
// Round-robin arbiter with multi-cycle grant tenure: an owner keeps the grant while it requests,
// for at most MAX_BURST cycles, then priority rotates to the requester after it with no bubble.
module rr_burst_arbiter #(
  parameter int unsigned N         = 8,
  parameter int unsigned ID_W      = 3,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  output logic [N-1:0]    gnt,
  output logic            gnt_valid,
  output logic [ID_W-1:0] gnt_id,
  output logic            burst_last
);

  localparam int unsigned    CntW   = $clog2(MAX_BURST + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(MAX_BURST);
  localparam logic [ID_W-1:0] IdLast = ID_W'(N - 1);
  localparam logic [N-1:0]    One    = N'(1);

  typedef enum logic {StIdle, StGrant} state_e;

  state_e          state_q, state_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [N-1:0]    gnt_q, gnt_d;
  logic            valid_q, valid_d;
  logic            last_q, last_d;

  // First set bit of r scanning upward from start, wrapping modulo N.
  function automatic logic [ID_W-1:0] pick(input logic [N-1:0] r, input logic [ID_W-1:0] start);
    logic        found;
    int unsigned idx;
    pick  = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = (32'(start) + i) % N;
      if (!found && r[idx]) begin
        found = 1'b1;
        pick  = ID_W'(idx);
      end
    end
  endfunction

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (|req) begin
          state_d = StGrant;
          id_d    = pick(req, ptr_q);
          cnt_d   = CntW'(1);
        end
      end
      StGrant: begin
        if (req[id_q] && (cnt_q != CntMax)) begin
          cnt_d = cnt_q + CntW'(1);
        end else begin
          // Release: the old owner drops to lowest priority for this and later arbitrations.
          ptr_d = (id_q == IdLast) ? '0 : id_q + ID_W'(1);
          if (|req) begin
            id_d  = pick(req, ptr_d);
            cnt_d = CntW'(1);
          end else begin
            state_d = StIdle;
            id_d    = '0;
            cnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = StIdle;
        id_d    = '0;
        cnt_d   = '0;
      end
    endcase
    valid_d = (state_d == StGrant);
    gnt_d   = valid_d ? (One << id_d) : '0;
    last_d  = valid_d && (cnt_d == CntMax);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      id_q    <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign gnt        = gnt_q;
  assign gnt_valid  = valid_q;
  assign gnt_id     = id_q;
  assign burst_last = last_q;

endmodule

// File: tb/tb_rr_burst_arbiter.sv
// Directed and random stimulus for rr_burst_arbiter, checked against a tenure-level reference
// model plus per-cycle invariants and a starvation bound.
module tb_rr_burst_arbiter;

  localparam int N     = 8;
  localparam int MB    = 4;
  localparam int BOUND = (N - 1) * MB + 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] req = '0;
  logic [N-1:0] gnt;
  logic         gnt_valid;
  logic [2:0]   gnt_id;
  logic         burst_last;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: current owner (-1 = none), priority pointer, cycles used in tenure.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_cnt   = 0;
  int waitc[N];

  rr_burst_arbiter #(.N(N), .ID_W(3), .MAX_BURST(MB)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id),
    .burst_last(burst_last)
  );

  always #5 clk = ~clk;

  function automatic int m_pick(input logic [N-1:0] r, input int start);
    for (int i = 0; i < N; i++) begin
      if (r[(start + i) % N]) return (start + i) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] m_gnt();
    logic [N-1:0] g;
    g = '0;
    if (m_owner >= 0) g[m_owner] = 1'b1;
    return g;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic [N-1:0] r, input logic rv);
    if (rv) begin
      m_owner = -1; m_ptr = 0; m_cnt = 0;
    end else if (m_owner < 0) begin
      if (r != 0) begin
        m_owner = m_pick(r, m_ptr); m_cnt = 1;
      end
    end else if (r[m_owner] && m_cnt != MB) begin
      m_cnt++;
    end else begin
      m_ptr = (m_owner + 1) % N;
      if (r != 0) begin
        m_owner = m_pick(r, m_ptr); m_cnt = 1;
      end else begin
        m_owner = -1; m_cnt = 0;
      end
    end
  endtask

  // One clock cycle: drive inputs, update waits, advance model, compare after the edge.
  task automatic step(input logic [N-1:0] r, input logic rv);
    logic [N-1:0] eg;
    int           worst;
    @(negedge clk);
    req = r;
    rst = rv;
    eg = m_gnt();
    worst = 0;
    for (int i = 0; i < N; i++) begin
      if (rv || !r[i] || eg[i]) waitc[i] = 0;
      else waitc[i]++;
      if (waitc[i] > worst) worst = waitc[i];
    end
    @(posedge clk);
    model_edge(r, rv);
    #1;
    eg = m_gnt();
    chk("gnt", 32'(gnt), 32'(eg));
    chk("gnt_valid", 32'(gnt_valid), 32'(m_owner >= 0));
    chk("gnt_id", 32'(gnt_id), (m_owner >= 0) ? 32'(m_owner) : 32'd0);
    chk("burst_last", 32'(burst_last), 32'((m_owner >= 0) && (m_cnt == MB)));
    chk("onehot0", 32'($onehot0(gnt)), 32'd1);
    chk("valid_or", 32'(gnt_valid), 32'(|gnt));
    chk("starve", 32'(worst <= BOUND), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < N; i++) waitc[i] = 0;

    // Reset with all requesting, then idle.
    step(8'hFF, 1'b1);
    step(8'hFF, 1'b1);
    chk("rst_gnt", 32'(gnt), 32'd0);
    step(8'h00, 1'b0);
    step(8'h00, 1'b0);
    chk("idle_gnt", 32'(gnt), 32'd0);

    // Single requester: 4-cycle tenure then immediate regrant.
    for (int k = 0; k < 4; k++) step(8'h04, 1'b0);
    chk("single_last", 32'(burst_last), 32'd1);
    step(8'h04, 1'b0);
    chk("single_regrant", 32'(gnt), 32'h04);
    chk("single_last_clr", 32'(burst_last), 32'd0);

    // Full contention from reset: owner index = (k/4) mod 8.
    step(8'hFF, 1'b1);
    for (int k = 0; k < 36; k++) begin
      step(8'hFF, 1'b0);
      chk("rot_id", 32'(gnt_id), 32'((k / MB) % N));
      chk("rot_last", 32'(burst_last), 32'((k % MB) == MB - 1));
    end

    // Early release of owner 0, then 7 wraps back to 0.
    step(8'h00, 1'b1);
    step(8'h81, 1'b0);
    chk("early_g0", 32'(gnt), 32'h01);
    step(8'h81, 1'b0);
    step(8'h80, 1'b0);
    chk("early_g7", 32'(gnt), 32'h80);
    for (int k = 0; k < 3; k++) step(8'h81, 1'b0);
    step(8'h81, 1'b0);
    chk("wrap_g0", 32'(gnt), 32'h01);

    // Reset in owner 1's second cycle.
    step(8'h00, 1'b1);
    step(8'h0A, 1'b0);
    step(8'h0A, 1'b0);
    step(8'h0A, 1'b1);
    chk("midrst_gnt", 32'(gnt), 32'd0);
    step(8'h0A, 1'b0);
    chk("midrst_regrant", 32'(gnt), 32'h02);

    // Late arrival of requester 5 in owner 3's final cycle.
    step(8'h00, 1'b1);
    for (int k = 0; k < 4; k++) step(8'h08, 1'b0);
    step(8'h28, 1'b0);
    chk("late_g5", 32'(gnt), 32'h20);
    for (int k = 0; k < 4; k++) step(8'h28, 1'b0);
    chk("late_g3", 32'(gnt), 32'h08);

    // Random traffic with occasional reset.
    for (int k = 0; k < 600; k++) begin
      logic [N-1:0] r;
      r = (k % 3 == 0) ? N'($urandom) : N'($urandom & $urandom);
      step(r, $urandom_range(0, 63) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_burst_arbiter.md
Name: rr_burst_arbiter

Overview:
- Round-robin arbiter that shares one resource among N requesters with multi-cycle grant tenure.
- A winner keeps its grant while it holds req, for up to MAX_BURST cycles. The grant then rotates to the next requester after the previous owner.
- Grants are registered and one-hot. Handover to a new owner has no bubble cycle.
- Sits in front of a shared bus or port, in place of a single-cycle rotating-priority arbiter, where requesters need back-to-back beats.

Parameters:
- N, 8, number of requesters.
- ID_W, 3, width of gnt_id; must equal clog2(N).
- MAX_BURST, 4, maximum consecutive grant cycles per tenure; must be >= 1.

Ports:
- clk  input  1  clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  N  request vector; bit i high means requester i wants the resource.
- gnt  output  N  registered one-hot grant; all zeros when no owner.
- gnt_valid  output  1  registered; equals |gnt.
- gnt_id  output  ID_W  registered index of the owner; 0 when gnt_valid=0.
- burst_last  output  1  registered; high in the owner's MAX_BURST-th grant cycle.

Behaviour:
- Reset: sampled on the clk edge only. Sets gnt=0, gnt_valid=0, gnt_id=0, burst_last=0, ptr=0, cnt=0, state=IDLE. Reset mid-tenure drops the grant on that edge; there is no completion of the burst.
- ptr (ID_W bits): index of the highest-priority requester. Priority runs ptr, ptr+1, ..., wrapping modulo N.
- cnt (clog2(MAX_BURST+1) bits): grant cycles used in the current tenure, including the current one.
- IDLE state:
  - req==0: remain IDLE, outputs zero.
  - req!=0: winner w = first set bit of req scanning from ptr. Next edge: gnt=onehot(w), gnt_id=w, gnt_valid=1, cnt=1, state=GRANT.
  - Latency: req rising in cycle t gives gnt in cycle t+1.
- GRANT state, owner o. The release condition in the current cycle is: req[o]==0 OR cnt==MAX_BURST.
  - No release: hold gnt, cnt increments.
  - Release with ptr_n=(o+1) mod N: ptr is updated to ptr_n.
    - Candidate set is the current req. Winner is the first set bit scanning from ptr_n, so o has lowest priority. o re-wins only if it is the sole requester.
    - Candidate set nonzero: next edge grants that winner with cnt=1 and no bubble.
    - Candidate set zero: next edge gnt=0, state=IDLE.
- Requester protocol: a requester deasserts req when done. Its gnt falls on the following edge, so exactly one trailing granted cycle has req low. That cycle counts in cnt but carries no transfer.
- burst_last: registered so that it is high exactly in the cycle where gnt is active and cnt==MAX_BURST.
  - Not asserted on an early release caused by req drop.
  - MAX_BURST=1: burst_last is high in every granted cycle; arbitration rotates every cycle, matching a plain round-robin arbiter.
- Wrap-around: owner N-1 releasing gives ptr=0.
- Simultaneous events:
  - Owner drop and burst expiry in the same cycle form a single release.
  - A new req arriving in the release cycle participates in that cycle's arbitration.
- Invariants, every cycle:
  - gnt is zero or one-hot.
  - gnt_valid==|gnt.
  - gnt_id==index(gnt) when valid.
  - No requester with req high waits more than (N-1)*MAX_BURST+1 cycles for gnt.

Test Plan:
- Reset/idle: assert rst with req=8'hFF for 2 cycles -> gnt=0, gnt_valid=0, burst_last=0 throughout. Release rst with req=0 -> outputs stay 0.
- Single requester, burst cap: req=8'h04 held -> gnt=8'h04 from the cycle after req for 4 cycles, with burst_last high in the 4th. Then the next tenure is immediately gnt=8'h04 again (sole requester), no bubble, cnt restarts.
- Full contention rotation: req=8'hFF held from reset -> owners 0,1,2,...,7,0 each for exactly 4 cycles, contiguous. gnt_id sequence matches; burst_last pulses every 4th cycle.
- Early release: req=8'h81 -> gnt=8'h01. Drop req[0] after 2 granted cycles -> gnt=8'h80 on the next edge, burst_last never high for owner 0. ptr wraps 7->0 after owner 7 releases.
- Reset mid-burst: req=8'h0A, then rst in owner 1's 2nd cycle -> gnt=0 at that edge. After rst low, owner 1 is regranted first (ptr=0), with cnt=1.
- Late arrival: owner 3 in its 4th cycle, with req[5] rising in that same cycle and req[3] still high -> gnt=8'h20 next edge. Owner 3 is regranted after requester 5's tenure if no other requester is ahead.
